stack_ptr_ctrl: RTL and testbench
=================================

STACK_PTR_CTRL -- requirements
Module: stack_ptr_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the stack pointer width.
REQ-002 The block SHALL have parameter SP_INIT, default {WIDTH{1'b1}}, giving the empty-stack pointer value loaded after reset.
REQ-003 The block SHALL have a single clock and a synchronous, active-high reset, with these ports (clock and reset first):
- CK  in  1  rising-edge clock.
- RST  in  1  synchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd  in  2  command code: 00 LOAD, 01 PUSH, 10 POP, 11 READ.
- cmd_data  in  WIDTH  LOAD value.
- cmd_ready  out  1  block can accept a command.
- LD_bar  out  1  counter load enable, active low.
- UD_bar  out  1  counter direction: 0 increment, 1 decrement.
- CBI_bar  out  1  counter count enable, active low.
- OE_bar  out  1  counter output enable, active low.
- A  out  WIDTH  counter load data.
- Y  in  WIDTH  counter output bus.
- rd_data  out  WIDTH  captured pointer value.
- rd_valid  out  1  one-cycle pulse: rd_data updated.
- err_full  out  1  one-cycle pulse: PUSH refused.
- err_empty  out  1  one-cycle pulse: POP refused.
- mismatch  out  1  sticky: counter readback differed from shadow.
- sp  out  WIDTH  shadow stack pointer.

Function
REQ-004 The block SHALL drive an external 8-bit up/down counter; the stack grows downward (PUSH decrements, POP increments).
REQ-005 All counter control outputs SHALL be registered; only one control action SHALL be issued per cycle.
REQ-006 The FSM SHALL have states INIT, IDLE, EXEC, RDBK.
REQ-007 INIT SHALL last exactly one cycle:
- drives LD_bar=0, A=SP_INIT, CBI_bar=1, OE_bar=1, cmd_ready=0;
- then goes to IDLE.
REQ-008 In IDLE, cmd_ready SHALL be 1, all control outputs SHALL be inactive (LD_bar=1, CBI_bar=1, OE_bar=1, UD_bar=0), and a command SHALL be accepted on a rising edge with cmd_valid=1 and cmd_ready=1.
REQ-009 A LOAD accepted at edge N SHALL:
- drive LD_bar=0, A=cmd_data during cycle N+1 (state EXEC, cmd_ready=0);
- set sp=cmd_data at edge N+1;
- return to IDLE.
REQ-010 A PUSH accepted at edge N with sp!=0 SHALL:
- drive CBI_bar=0, UD_bar=1 during cycle N+1;
- set sp=sp-1 at edge N+1;
- return to IDLE.
REQ-011 A POP accepted at edge N with sp!=SP_INIT SHALL:
- drive CBI_bar=0, UD_bar=0 during cycle N+1;
- set sp=sp+1 at edge N+1;
- return to IDLE.
REQ-012 A PUSH accepted with sp==0 SHALL issue no counter action, SHALL leave sp unchanged, SHALL pulse err_full for cycle N+1, and SHALL stay in IDLE with cmd_ready=1.
REQ-013 A POP accepted with sp==SP_INIT SHALL issue no counter action, SHALL leave sp unchanged, SHALL pulse err_empty for cycle N+1, and SHALL stay in IDLE.
REQ-014 A READ accepted at edge N SHALL:
- drive OE_bar=0 during cycles N+1 and N+2 (state RDBK, cmd_ready=0);
- capture Y into rd_data at edge N+2;
- pulse rd_valid during cycle N+3;
- return to IDLE at edge N+2.
REQ-015 At the READ capture edge, if Y!=sp, mismatch SHALL set to 1 and remain 1 until reset.
REQ-016 Pointer arithmetic SHALL be modulo 2^WIDTH, but REQ-012/013 SHALL prevent wrap through PUSH/POP; LOAD SHALL accept any value, including 0 and SP_INIT.
REQ-017 LD_bar and CBI_bar SHALL never both be 0 in the same cycle; OE_bar SHALL be 0 only in RDBK.
REQ-018 Commands offered while cmd_ready=0 SHALL be ignored and SHALL not be lost from the source, which holds cmd_valid until accepted.

Reset
REQ-019 RST=1 at a rising edge SHALL take precedence over any state or command, including an in-progress EXEC or RDBK.
REQ-020 After a reset edge, outputs SHALL be:
- state=INIT, sp=SP_INIT, rd_data=0;
- rd_valid=0, err_full=0, err_empty=0, mismatch=0, cmd_ready=0;
- LD_bar=1, CBI_bar=1, OE_bar=1, UD_bar=0, A=0.
REQ-021 The first cycle after RST deasserts SHALL be INIT (REQ-007), so the counter is reloaded with SP_INIT before any command is accepted.

Verification
REQ-022 Reset, then READ -> INIT drives LD_bar=0 with A=8'hFF; rd_data=8'hFF, rd_valid pulses once, mismatch=0.
REQ-023 Three PUSH, then one POP -> exactly three CBI_bar=0/UD_bar=1 cycles, then one CBI_bar=0/UD_bar=0 cycle; sp=8'hFD; READ returns 8'hFD.
REQ-024 LOAD 8'h00, then PUSH -> no CBI_bar=0 cycle; err_full pulses one cycle; sp stays 8'h00. With SP_INIT, POP -> err_empty pulses; sp stays 8'hFF.
REQ-025 Counter model forced so Y differs from sp (e.g. Y=8'h10, sp=8'h11), then READ -> mismatch=1 and stays 1 through later commands until RST.
REQ-026 RST asserted during RDBK (OE_bar=0) -> next cycle OE_bar=1, no rd_valid pulse, state INIT, sp=SP_INIT.
REQ-027 cmd_valid held high with alternating PUSH/POP for 20 cycles -> one command accepted every 2 cycles; LD_bar and CBI_bar never both 0; final sp matches the counter model.

Source files
------------

// File: rtl/stack_ptr_ctrl.sv
// Stack pointer controller driving an external up/down counter. It keeps a shadow
// pointer, refuses PUSH/POP past the stack limits and checks counter readbacks against the shadow.
module stack_ptr_ctrl #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] SP_INIT = {WIDTH{1'b1}}
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             cmd_ready,
    output logic             LD_bar,
    output logic             UD_bar,
    output logic             CBI_bar,
    output logic             OE_bar,
    output logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             err_full,
    output logic             err_empty,
    output logic             mismatch,
    output logic [WIDTH-1:0] sp
);
    typedef enum logic [1:0] {INIT, IDLE, EXEC, RDBK} state_t;

    localparam logic [1:0] CMD_LOAD = 2'b00;
    localparam logic [1:0] CMD_PUSH = 2'b01;
    localparam logic [1:0] CMD_POP  = 2'b10;
    localparam logic [1:0] CMD_READ = 2'b11;

    state_t           state_reg, state_next;
    logic [1:0]       op_reg, op_next;
    logic             rd_phase_reg, rd_phase_next;
    logic             ld_bar_reg, ld_bar_next;
    logic             ud_bar_reg, ud_bar_next;
    logic             cbi_bar_reg, cbi_bar_next;
    logic             oe_bar_reg, oe_bar_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] sp_reg, sp_next;
    logic [WIDTH-1:0] rd_data_reg, rd_data_next;
    logic             rd_valid_reg, rd_valid_next;
    logic             err_full_reg, err_full_next;
    logic             err_empty_reg, err_empty_next;
    logic             mismatch_reg, mismatch_next;
    logic             cmd_ready_reg, cmd_ready_next;

    always_ff @(posedge CK) begin
        if (RST) begin
            state_reg     <= INIT;
            op_reg        <= CMD_LOAD;
            rd_phase_reg  <= 1'b0;
            ld_bar_reg    <= 1'b1;
            ud_bar_reg    <= 1'b0;
            cbi_bar_reg   <= 1'b1;
            oe_bar_reg    <= 1'b1;
            a_reg         <= '0;
            sp_reg        <= SP_INIT;
            rd_data_reg   <= '0;
            rd_valid_reg  <= 1'b0;
            err_full_reg  <= 1'b0;
            err_empty_reg <= 1'b0;
            mismatch_reg  <= 1'b0;
            cmd_ready_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            op_reg        <= op_next;
            rd_phase_reg  <= rd_phase_next;
            ld_bar_reg    <= ld_bar_next;
            ud_bar_reg    <= ud_bar_next;
            cbi_bar_reg   <= cbi_bar_next;
            oe_bar_reg    <= oe_bar_next;
            a_reg         <= a_next;
            sp_reg        <= sp_next;
            rd_data_reg   <= rd_data_next;
            rd_valid_reg  <= rd_valid_next;
            err_full_reg  <= err_full_next;
            err_empty_reg <= err_empty_next;
            mismatch_reg  <= mismatch_next;
            cmd_ready_reg <= cmd_ready_next;
        end
    end

    // Every output is registered, so each branch computes what the counter sees next cycle.
    always_comb begin
        state_next     = state_reg;
        op_next        = op_reg;
        rd_phase_next  = 1'b0;
        ld_bar_next    = 1'b1;
        ud_bar_next    = 1'b0;
        cbi_bar_next   = 1'b1;
        oe_bar_next    = 1'b1;
        a_next         = a_reg;
        sp_next        = sp_reg;
        rd_data_next   = rd_data_reg;
        rd_valid_next  = 1'b0;
        err_full_next  = 1'b0;
        err_empty_next = 1'b0;
        mismatch_next  = mismatch_reg;
        cmd_ready_next = 1'b0;

        case (state_reg)
            INIT: begin
                // Reset leaves the load strobe idle; the first free cycle issues the SP_INIT load.
                if (ld_bar_reg) begin
                    ld_bar_next = 1'b0;
                    a_next      = SP_INIT;
                end else begin
                    state_next     = IDLE;
                    cmd_ready_next = 1'b1;
                end
            end
            IDLE: begin
                cmd_ready_next = 1'b1;
                if (cmd_valid && cmd_ready_reg) begin
                    op_next = cmd;
                    case (cmd)
                        CMD_LOAD: begin
                            state_next     = EXEC;
                            ld_bar_next    = 1'b0;
                            a_next         = cmd_data;
                            cmd_ready_next = 1'b0;
                        end
                        CMD_PUSH: begin
                            if (sp_reg == '0) begin
                                err_full_next = 1'b1;
                            end else begin
                                state_next     = EXEC;
                                cbi_bar_next   = 1'b0;
                                ud_bar_next    = 1'b1;
                                cmd_ready_next = 1'b0;
                            end
                        end
                        CMD_POP: begin
                            if (sp_reg == SP_INIT) begin
                                err_empty_next = 1'b1;
                            end else begin
                                state_next     = EXEC;
                                cbi_bar_next   = 1'b0;
                                cmd_ready_next = 1'b0;
                            end
                        end
                        default: begin
                            state_next     = RDBK;
                            oe_bar_next    = 1'b0;
                            cmd_ready_next = 1'b0;
                        end
                    endcase
                end
            end
            EXEC: begin
                state_next     = IDLE;
                cmd_ready_next = 1'b1;
                case (op_reg)
                    CMD_LOAD: sp_next = a_reg;
                    CMD_PUSH: sp_next = sp_reg - WIDTH'(1);
                    CMD_POP:  sp_next = sp_reg + WIDTH'(1);
                    default:  sp_next = sp_reg;
                endcase
            end
            RDBK: begin
                if (!rd_phase_reg) begin
                    rd_phase_next = 1'b1;
                    oe_bar_next   = 1'b0;
                end else begin
                    state_next     = IDLE;
                    cmd_ready_next = 1'b1;
                    rd_data_next   = Y;
                    rd_valid_next  = 1'b1;
                    if (Y != sp_reg) begin
                        mismatch_next = 1'b1;
                    end
                end
            end
            default: state_next = INIT;
        endcase
    end

    assign cmd_ready = cmd_ready_reg;
    assign LD_bar    = ld_bar_reg;
    assign UD_bar    = ud_bar_reg;
    assign CBI_bar   = cbi_bar_reg;
    assign OE_bar    = oe_bar_reg;
    assign A         = a_reg;
    assign rd_data   = rd_data_reg;
    assign rd_valid  = rd_valid_reg;
    assign err_full  = err_full_reg;
    assign err_empty = err_empty_reg;
    assign mismatch  = mismatch_reg;
    assign sp        = sp_reg;
endmodule

// File: tb/tb_stack_ptr_ctrl.sv
// Directed bench for stack_ptr_ctrl with a behavioural up/down counter on the control bus
// and a queue of expected readback values matched against rd_valid pulses.
module tb_stack_ptr_ctrl;
    localparam logic [1:0] C_LOAD = 2'b00;
    localparam logic [1:0] C_PUSH = 2'b01;
    localparam logic [1:0] C_POP  = 2'b10;
    localparam logic [1:0] C_READ = 2'b11;

    logic       CK = 1'b0;
    logic       RST = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready, LD_bar, UD_bar, CBI_bar, OE_bar;
    logic [7:0] A, Y, rd_data, sp;
    logic       rd_valid, err_full, err_empty, mismatch;

    logic [7:0] cnt = 8'h00;
    logic [7:0] corrupt = 8'h00;
    logic [7:0] exp_sp;
    logic [7:0] exp_q[$];

    int checks = 0;
    int errors = 0;
    int n_push_act = 0, n_pop_act = 0, n_ld = 0, n_errf = 0, n_erre = 0, n_rdv = 0;

    stack_ptr_ctrl #(.WIDTH(8), .SP_INIT(8'hFF)) dut (
        .CK(CK), .RST(RST), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .LD_bar(LD_bar), .UD_bar(UD_bar), .CBI_bar(CBI_bar),
        .OE_bar(OE_bar), .A(A), .Y(Y), .rd_data(rd_data), .rd_valid(rd_valid),
        .err_full(err_full), .err_empty(err_empty), .mismatch(mismatch), .sp(sp)
    );

    always #5 CK = ~CK;

    // External counter: load has priority over count; corrupt lets a test fake a bad readback.
    always @(posedge CK) begin
        if (!LD_bar) cnt <= A;
        else if (!CBI_bar) cnt <= UD_bar ? cnt - 8'd1 : cnt + 8'd1;
    end
    assign Y = OE_bar ? 8'h00 : (cnt ^ corrupt);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor and scoreboard consumer, sampled on the falling edge.
    always @(negedge CK) begin
        if (!RST) check("ld_cbi_exclusive", {31'd0, (!LD_bar && !CBI_bar)}, 32'd0);
        if (!LD_bar) n_ld++;
        if (!CBI_bar && UD_bar) n_push_act++;
        if (!CBI_bar && !UD_bar) n_pop_act++;
        if (err_full) n_errf++;
        if (err_empty) n_erre++;
        if (rd_valid) begin
            n_rdv++;
            if (exp_q.size() == 0) begin
                check("rd_valid_unexpected", 32'd1, 32'd0);
            end else begin
                check("rd_data", {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge CK);
            n++;
        end
        #1;
        if (!cmd_ready) begin
            checks++;
            errors++;
            $error("FAIL ready_timeout observed=0 expected=1");
        end
    endtask

    task automatic issue(input logic [1:0] c, input logic [7:0] d);
        wait_ready();
        cmd_valid = 1'b1;
        cmd = c;
        cmd_data = d;
        @(posedge CK);
        #1 cmd_valid = 1'b0;
        @(negedge CK);
        #1;
        $display("cmd=%0d data=%02h sp=%02h cnt=%02h", c, d, sp, cnt);
    endtask

    task automatic model_push();
        if (exp_sp != 8'h00) exp_sp = exp_sp - 8'd1;
    endtask

    task automatic model_pop();
        if (exp_sp != 8'hFF) exp_sp = exp_sp + 8'd1;
    endtask

    initial begin
        int base_push, base_pop, base_ld, base_errf, base_erre, base_rdv, acc, w;

        // Reset state
        repeat (3) @(posedge CK);
        @(negedge CK);
        #1;
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_ctrl", {28'd0, LD_bar, CBI_bar, OE_bar, UD_bar}, 32'hE);
        check("rst_A", {24'd0, A}, 32'h00);
        check("rst_sp", {24'd0, sp}, 32'hFF);
        check("rst_rd_data", {24'd0, rd_data}, 32'h00);
        check("rst_flags", {28'd0, rd_valid, err_full, err_empty, mismatch}, 32'h0);
        RST = 1'b0;
        exp_sp = 8'hFF;

        // Initial counter load before any command is accepted
        w = 0;
        while (LD_bar && w < 10) begin
            @(negedge CK);
            w++;
        end
        #1;
        check("init_ld", {31'd0, LD_bar}, 32'd0);
        check("init_A", {24'd0, A}, 32'hFF);
        check("init_not_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge CK);
        #1;
        check("init_to_idle", {30'd0, cmd_ready, LD_bar}, 32'h3);

        // READ after reset returns SP_INIT
        base_rdv = n_rdv;
        exp_q.push_back(exp_sp);
        issue(C_READ, 8'h00);
        check("read_oe", {31'd0, OE_bar}, 32'd0);
        wait_ready();
        @(negedge CK);
        #1;
        check("read_rdv_once", n_rdv - base_rdv, 32'd1);
        check("read_no_mismatch", {31'd0, mismatch}, 32'd0);

        // Three PUSH then one POP
        base_push = n_push_act;
        base_pop = n_pop_act;
        repeat (3) begin
            issue(C_PUSH, 8'h00);
            model_push();
        end
        issue(C_POP, 8'h00);
        model_pop();
        wait_ready();
        check("push_actions", n_push_act - base_push, 32'd3);
        check("pop_actions", n_pop_act - base_pop, 32'd1);
        check("sp_after_pushpop", {24'd0, sp}, {24'd0, exp_sp});
        exp_q.push_back(exp_sp);
        issue(C_READ, 8'h00);
        wait_ready();
        @(negedge CK);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);

        // PUSH at sp==0 is refused
        issue(C_LOAD, 8'h00);
        exp_sp = 8'h00;
        wait_ready();
        base_push = n_push_act;
        base_errf = n_errf;
        issue(C_PUSH, 8'h00);
        model_push();
        check("full_ready_kept", {31'd0, cmd_ready}, 32'd1);
        @(negedge CK);
        #1;
        check("full_no_count", n_push_act - base_push, 32'd0);
        check("full_pulse", n_errf - base_errf, 32'd1);
        check("full_sp", {24'd0, sp}, {24'd0, exp_sp});

        // POP at SP_INIT is refused
        issue(C_LOAD, 8'hFF);
        exp_sp = 8'hFF;
        wait_ready();
        base_pop = n_pop_act;
        base_erre = n_erre;
        issue(C_POP, 8'h00);
        model_pop();
        @(negedge CK);
        #1;
        check("empty_no_count", n_pop_act - base_pop, 32'd0);
        check("empty_pulse", n_erre - base_erre, 32'd1);
        check("empty_sp", {24'd0, sp}, {24'd0, exp_sp});

        // Back-to-back alternating PUSH/POP with cmd_valid held high
        wait_ready();
        base_push = n_push_act;
        base_pop = n_pop_act;
        base_ld = n_ld;
        acc = 0;
        cmd_valid = 1'b1;
        cmd = C_PUSH;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) begin
                acc++;
                if (cmd == C_PUSH) model_push(); else model_pop();
                @(posedge CK);
                #1 cmd = (cmd == C_PUSH) ? C_POP : C_PUSH;
            end else begin
                @(posedge CK);
            end
            @(negedge CK);
            #1;
        end
        cmd_valid = 1'b0;
        check("stream_accepts", acc, 32'd10);
        check("stream_pushes", n_push_act - base_push, 32'd5);
        check("stream_pops", n_pop_act - base_pop, 32'd5);
        check("stream_no_load", n_ld - base_ld, 32'd0);
        check("stream_sp_model", {24'd0, sp}, {24'd0, exp_sp});
        check("stream_sp_counter", {24'd0, sp}, {24'd0, cnt});

        // Readback mismatch is sticky
        issue(C_LOAD, 8'h11);
        exp_sp = 8'h11;
        wait_ready();
        corrupt = 8'h01;
        exp_q.push_back(exp_sp ^ corrupt);
        issue(C_READ, 8'h00);
        wait_ready();
        @(negedge CK);
        #1;
        corrupt = 8'h00;
        check("mismatch_set", {31'd0, mismatch}, 32'd1);
        issue(C_PUSH, 8'h00);
        model_push();
        issue(C_LOAD, 8'h40);
        exp_sp = 8'h40;
        wait_ready();
        check("mismatch_sticky", {31'd0, mismatch}, 32'd1);
        check("sp_after_load", {24'd0, sp}, {24'd0, exp_sp});

        // Reset during readback aborts the READ
        base_rdv = n_rdv;
        issue(C_READ, 8'h00);
        check("rdbk_oe_active", {31'd0, OE_bar}, 32'd0);
        RST = 1'b1;
        @(negedge CK);
        #1;
        RST = 1'b0;
        exp_sp = 8'hFF;
        check("abort_oe", {31'd0, OE_bar}, 32'd1);
        check("abort_ready", {31'd0, cmd_ready}, 32'd0);
        check("abort_sp", {24'd0, sp}, {24'd0, exp_sp});
        check("abort_mismatch_clr", {31'd0, mismatch}, 32'd0);
        repeat (4) @(negedge CK);
        #1;
        check("abort_no_rdv", n_rdv - base_rdv, 32'd0);
        exp_q.push_back(exp_sp);
        issue(C_READ, 8'h00);
        wait_ready();
        @(negedge CK);
        #1;
        check("final_queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
